// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Register offsets and shared constants for the iomem GPIO
//                peripheral.
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_pkg;

    // Widest supported pin count; also the bus data width.
    localparam int GPIO_MAX_WIDTH = 32;

    // Byte offsets inside the 256-byte window (addr[7:0]).
    localparam logic [7:0] GPIO_OUT     = 8'h00;
    localparam logic [7:0] GPIO_OE      = 8'h04;
    localparam logic [7:0] GPIO_IN      = 8'h08;
    localparam logic [7:0] GPIO_RISE_EN = 8'h0C;
    localparam logic [7:0] GPIO_FALL_EN = 8'h10;
    localparam logic [7:0] GPIO_STATUS  = 8'h14;
    localparam logic [7:0] GPIO_OUT_SET = 8'h18;
    localparam logic [7:0] GPIO_OUT_CLR = 8'h1C;

    // Expand 4 byte strobes into a 32-bit bit mask.
    function automatic logic [GPIO_MAX_WIDTH-1:0] strb_to_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_edge_sync
//  Description : Multi-flop input synchroniser followed by a previous-value
//                register; produces one-clock rise/fall pulses per pin.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_edge_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_in_s,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Synchroniser chain: stage 0 captures the asynchronous pads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Previous-value register gives the one-clock history for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_in_s = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule : gpio_edge_sync
`default_nettype wire

// File: rtl/iomem_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_gpio
//  Description : Parametrised GPIO on the picosoc iomem bus: output and
//                output-enable registers, atomic set/clear, synchronised
//                inputs and per-pin edge interrupts with W1C status.
//  Revision    : 1.0  initial release
// ============================================================================
module iomem_gpio
    import gpio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter logic [31:0] RESET_OUT   = 32'h4,
    parameter logic [31:0] RESET_OE    = 32'h7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    // Register state
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_status;
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic             r_irq;

    // Input path
    logic [WIDTH-1:0] w_in_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Bus decode
    logic             w_sel;
    logic             w_wr;
    logic [7:0]       w_off;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_rd;
    logic [31:0]      w_rd32;

    // Next-state values
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_oe_nxt;
    logic [WIDTH-1:0] w_rise_en_nxt;
    logic [WIDTH-1:0] w_fall_en_nxt;
    logic [WIDTH-1:0] w_status_clr;
    logic [WIDTH-1:0] w_status_set;

    // Address bits that do not take part in decoding and data bits above WIDTH.
    logic             w_unused;
    logic [31:0]      w_mask32;

    gpio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_in   (gpio_in),
        .o_in_s (w_in_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_sel    = iomem_valid & ~r_ready & (iomem_addr[31:24] == BASE_ADDR);
    assign w_wr     = w_sel & (|iomem_wstrb);
    assign w_off    = {iomem_addr[7:2], 2'b00};
    assign w_mask32 = strb_to_mask(iomem_wstrb);
    assign w_mask   = w_mask32[WIDTH-1:0];
    assign w_wd     = iomem_wdata[WIDTH-1:0];
    assign w_wmask  = w_wd & w_mask;
    assign w_unused = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, w_mask32};

    // Read mux: always reflects the pre-write register contents.
    always_comb begin
        w_rd = '0;
        case (w_off)
            GPIO_OUT:     w_rd = r_out;
            GPIO_OE:      w_rd = r_oe;
            GPIO_IN:      w_rd = w_in_s;
            GPIO_RISE_EN: w_rd = r_rise_en;
            GPIO_FALL_EN: w_rd = r_fall_en;
            GPIO_STATUS:  w_rd = r_status;
            default:      w_rd = '0;
        endcase
        w_rd32            = '0;
        w_rd32[WIDTH-1:0] = w_rd;
    end

    // Write decode with per-byte merge for RW registers and masked SET/CLR/W1C.
    always_comb begin
        w_out_nxt     = r_out;
        w_oe_nxt      = r_oe;
        w_rise_en_nxt = r_rise_en;
        w_fall_en_nxt = r_fall_en;
        w_status_clr  = '0;
        if (w_wr) begin
            case (w_off)
                GPIO_OUT:     w_out_nxt     = (r_out & ~w_mask) | w_wmask;
                GPIO_OE:      w_oe_nxt      = (r_oe & ~w_mask) | w_wmask;
                GPIO_RISE_EN: w_rise_en_nxt = (r_rise_en & ~w_mask) | w_wmask;
                GPIO_FALL_EN: w_fall_en_nxt = (r_fall_en & ~w_mask) | w_wmask;
                GPIO_STATUS:  w_status_clr  = w_wmask;
                GPIO_OUT_SET: w_out_nxt     = r_out | w_wmask;
                GPIO_OUT_CLR: w_out_nxt     = r_out & ~w_wmask;
                default:      w_out_nxt     = r_out;
            endcase
        end
    end

    // Enabled edges feed STATUS; enables do not affect already-pending bits.
    assign w_status_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);

    // Control/config registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out     <= RESET_OUT[WIDTH-1:0];
            r_oe      <= RESET_OE[WIDTH-1:0];
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else begin
            r_out     <= w_out_nxt;
            r_oe      <= w_oe_nxt;
            r_rise_en <= w_rise_en_nxt;
            r_fall_en <= w_fall_en_nxt;
        end
    end

    // Pending status: a new edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_status_clr) | w_status_set;
        end
    end

    // Single-cycle acknowledge with registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd32 : 32'h0;
        end
    end

    // Registered interrupt follows STATUS by one clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_status;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_oe;
    assign irq         = r_irq;

endmodule : iomem_gpio
`default_nettype wire

// File: tb/tb_iomem_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_gpio
//  Description : Directed self-checking bench for iomem_gpio (WIDTH=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iomem_gpio;

    localparam int WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [31:0]      iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             irq;

    int n_chk;
    int n_pass;

    iomem_gpio #(
        .WIDTH       (WIDTH),
        .BASE_ADDR   (8'h03),
        .RESET_OUT   (32'h4),
        .RESET_OE    (32'h7),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transfer; checks latency of exactly one clock and that ready drops after.
    task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata);
        int lat;
        lat         = 0;
        rdata       = 32'h0;
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = strb;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (iomem_ready) begin
                lat   = c;
                rdata = iomem_rdata;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        chk({tag, "_lat"}, lat, 1);
        tick();
        chk({tag, "_rdy_drop"}, {31'h0, iomem_ready}, 0);
    endtask

    logic [31:0] rd;
    int          cnt;
    int          irq_lat;

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        gpio_in     = '0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset values
        chk("rst_out",   {24'h0, gpio_out}, 32'h04);
        chk("rst_oe",    {24'h0, gpio_oe},  32'h07);
        chk("rst_irq",   {31'h0, irq},      0);
        chk("rst_ready", {31'h0, iomem_ready}, 0);

        bus("rd_out_rst", 32'h0300_0000, 32'h0, 4'h0, rd);
        chk("rd_out_rst_data", rd, 32'h4);

        // Byte-strobed write; returns pre-write value
        bus("wr_out_b0", 32'h0300_0000, 32'hFFFF_FFA5, 4'b0001, rd);
        chk("wr_out_prewrite", rd, 32'h4);
        chk("pin_out_a5", {24'h0, gpio_out}, 32'hA5);
        bus("rd_out_a5", 32'h0300_0000, 32'h0, 4'h0, rd);
        chk("rd_out_a5_data", rd, 32'h0000_00A5);

        // Strobe 0 byte must not change OE
        bus("wr_oe_nostrb", 32'h0300_0004, 32'h0000_00FF, 4'b0010, rd);
        chk("pin_oe_keep", {24'h0, gpio_oe}, 32'h07);

        // Atomic set/clear
        bus("wr_out_f0", 32'h0300_0000, 32'h0000_00F0, 4'hF, rd);
        chk("pin_out_f0", {24'h0, gpio_out}, 32'hF0);
        bus("wr_set", 32'h0300_0018, 32'h0000_000F, 4'hF, rd);
        chk("pin_out_set", {24'h0, gpio_out}, 32'hFF);
        bus("wr_clr", 32'h0300_001C, 32'h0000_0081, 4'hF, rd);
        chk("pin_out_clr", {24'h0, gpio_out}, 32'h7E);
        bus("rd_set", 32'h0300_0018, 32'h0, 4'h0, rd);
        chk("rd_set_zero", rd, 32'h0);
        bus("rd_clr", 32'h0300_001C, 32'h0, 4'h0, rd);
        chk("rd_clr_zero", rd, 32'h0);

        // Rising-edge interrupt on pin 0
        bus("wr_rise_en", 32'h0300_000C, 32'h0000_0001, 4'hF, rd);
        gpio_in[0] = 1'b1;
        irq_lat    = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (irq) begin
                irq_lat = c;
                break;
            end
        end
        chk("irq_rise_lat", irq_lat, 4);
        bus("rd_status1", 32'h0300_0014, 32'h0, 4'h0, rd);
        chk("rd_status1_data", rd, 32'h1);
        bus("rd_in", 32'h0300_0008, 32'h0, 4'h0, rd);
        chk("rd_in_data", rd, 32'h1);

        // W1C clears status, irq follows one clock later
        bus("w1c", 32'h0300_0014, 32'h0000_0001, 4'hF, rd);
        chk("w1c_prewrite", rd, 32'h1);
        chk("irq_clear", {31'h0, irq}, 0);
        bus("rd_status0", 32'h0300_0014, 32'h0, 4'h0, rd);
        chk("rd_status0_data", rd, 32'h0);

        // Falling edge with FALL_EN=0 sets nothing
        gpio_in[0] = 1'b0;
        repeat (6) tick();
        bus("rd_status_fall", 32'h0300_0014, 32'h0, 4'h0, rd);
        chk("rd_status_fall_data", rd, 32'h0);
        chk("irq_fall", {31'h0, irq}, 0);

        // Rising edge lands in the same cycle as the W1C commit
        gpio_in[0] = 1'b1;
        tick();
        tick();
        bus("w1c_race", 32'h0300_0014, 32'h0000_0001, 4'hF, rd);
        bus("rd_status_race", 32'h0300_0014, 32'h0, 4'h0, rd);
        chk("rd_status_race_data", rd, 32'h1);
        chk("irq_race", {31'h0, irq}, 1);

        // Unmapped offset: single ready, rdata 0, no state change
        bus("unmapped", 32'h0300_0020, 32'hFFFF_FFFF, 4'hF, rd);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_out", {24'h0, gpio_out}, 32'h7E);
        chk("unmapped_oe",  {24'h0, gpio_oe},  32'h07);

        // Foreign address: never acknowledged
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000;
        iomem_wstrb = 4'h0;
        cnt         = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (iomem_ready) cnt++;
        end
        iomem_valid = 1'b0;
        chk("foreign_ready", cnt, 0);

        // Reset asserted while ready is high aborts the access
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        tick();
        chk("pre_rst_ready", {31'h0, iomem_ready}, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, iomem_ready}, 0);
        chk("mid_rst_out",   {24'h0, gpio_out}, 32'h04);
        chk("mid_rst_oe",    {24'h0, gpio_oe},  32'h07);
        chk("mid_rst_irq",   {31'h0, irq},      0);
        iomem_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        bus("rd_status_rst", 32'h0300_0014, 32'h0, 4'h0, rd);
        chk("rd_status_rst_data", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_iomem_gpio
`default_nettype wire
